wb_regbank: RTL and testbench
=============================

Name: wb_regbank

Overview:
- Architectural state bank at the end of the pipeline. It consumes the write-back bundle registered by the memory/write-back pipeline register.
- Holds the 32x32 general-purpose register file, the HI/LO pair and the LLbit.
- Provides two GPR read ports to the decode stage and HI/LO/LLbit read values to the execute and memory stages.
- Commits all architectural writes on the rising clock edge.

Parameters:
- NREGS, 32, number of GPRs; the address width is fixed at 5.
- DW, 32, data width of GPRs, HI and LO.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- wb_wd  input  5  GPR destination address.
- wb_wreg  input  1  GPR write enable.
- wb_wdata  input  DW  GPR write data.
- wb_hi  input  DW  HI write data.
- wb_lo  input  DW  LO write data.
- wb_whilo  input  1  HI/LO write enable; writes both registers.
- wb_LLbit_we  input  1  LLbit write enable.
- wb_LLbit_value  input  1  LLbit write value.
- flush  input  1  exception/eret flush; clears LLbit.
- re1  input  1  read port 1 enable.
- raddr1  input  5  read port 1 address.
- rdata1  output  DW  read port 1 data.
- re2  input  1  read port 2 enable.
- raddr2  input  5  read port 2 address.
- rdata2  output  DW  read port 2 data.
- hi_o  output  DW  current HI.
- lo_o  output  DW  current LO.
- LLbit_o  output  1  current LLbit.

Behaviour:
- Reset (synchronous, active-high): on a posedge with rst=1, all GPRs, HI, LO and LLbit become 0. All write inputs are ignored that cycle.
- Outputs while rst=1: rdata1, rdata2, hi_o, lo_o and LLbit_o are forced to 0 combinationally.
- GPR write: on posedge, if wb_wreg=1 and wb_wd!=0, then GPR[wb_wd] <= wb_wdata.
- Register $0: a write to address 0 is discarded; $0 always reads 0.
- GPR read ports: combinational, zero-cycle latency.
  - rdataN = 0 if rst=1, reN=0 or raddrN=0.
  - Otherwise rdataN = GPR[raddrN], subject to the bypass rule under Optional Feature.
  - Both ports may read the same address in the same cycle.
- HI/LO: on posedge, if wb_whilo=1 then HI <= wb_hi and LO <= wb_lo. No partial write exists.
- LLbit update priority on posedge:
  - rst first.
  - then flush=1: LLbit <= 0, even if wb_LLbit_we=1 that cycle.
  - then wb_LLbit_we=1: LLbit <= wb_LLbit_value.
  - otherwise hold.
- flush does not block GPR or HI/LO writes. The upstream register already squashes the bundle.
- Registered write latency: a write presented in cycle N is visible in stored state from cycle N+1.
- Reset deasserting mid-stream: the first posedge with rst=0 accepts writes normally. No warm-up cycle.
- X inputs with the corresponding enable low must not corrupt state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If reN=1, raddrN!=0, wb_wreg=1 and wb_wd==raddrN, then rdataN = wb_wdata.
  - If wb_whilo=1, then hi_o = wb_hi and lo_o = wb_lo.
  - LLbit_o = 0 if flush=1; else wb_LLbit_value if wb_LLbit_we=1; else stored LLbit.
  - rst=1 still forces all outputs to 0.
- Undefined: all outputs reflect stored state only. The write-back-to-decode hazard must then be resolved by stalling upstream.

Test Plan:
- Reset: hold rst=1 for 2 cycles with wb_wreg=1, wb_wd=5, wb_wdata=32'hDEAD_BEEF -> all outputs 0 throughout; after release, a read of r5 returns 0.
- Write then read: write r7=32'h1234_5678, then next cycle re1=1, raddr1=7 -> rdata1=32'h1234_5678; with re1=0 -> rdata1=0.
- $0 protection: write wb_wd=0, wb_wdata=32'hFFFF_FFFF, then read raddr1=raddr2=0 with re=1 -> both 0.
- Same-cycle read of the address being written: write r3=32'hA5A5_A5A5 while raddr2=3.
  - With WB_BYPASS_EN: rdata2=32'hA5A5_A5A5 in the same cycle.
  - Without it: old value that cycle, new value the next cycle.
- HI/LO: wb_whilo=1, wb_hi=32'h1, wb_lo=32'h2 -> hi_o=1, lo_o=2 after the edge (same cycle with bypass). A following cycle with wb_whilo=0 and other data -> hi_o and lo_o unchanged.
- LLbit priority: set LLbit via we=1, value=1 -> LLbit_o=1. Then flush=1 together with we=1, value=1 -> LLbit_o=0 after the edge. Then we=0, flush=0 -> stays 0.

Source files
------------

// File: rtl/wb_regbank.sv
// Write-back architectural state: 32x32 GPR file, HI/LO pair and LLbit.
// Define WB_BYPASS_EN to forward the same-cycle write-back bundle to the read outputs.
module wb_regbank #(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    wb_wd,
    input  logic          wb_wreg,
    input  logic [DW-1:0] wb_wdata,
    input  logic [DW-1:0] wb_hi,
    input  logic [DW-1:0] wb_lo,
    input  logic          wb_whilo,
    input  logic          wb_LLbit_we,
    input  logic          wb_LLbit_value,
    input  logic          flush,
    input  logic          re1,
    input  logic [4:0]    raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          re2,
    input  logic [4:0]    raddr2,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic          LLbit_o
);

    logic [DW-1:0] gpr_q [NREGS];
    logic [DW-1:0] hi_q, lo_q;
    logic          llbit_q, llbit_d;

    // flush outranks a same-cycle LLbit write
    always_comb begin
        llbit_d = llbit_q;
        if (flush)            llbit_d = 1'b0;
        else if (wb_LLbit_we) llbit_d = wb_LLbit_value;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) gpr_q[i] <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            llbit_q <= 1'b0;
        end else begin
            if (wb_wreg && wb_wd != 5'd0) gpr_q[wb_wd] <= wb_wdata;
            if (wb_whilo) begin
                hi_q <= wb_hi;
                lo_q <= wb_lo;
            end
            llbit_q <= llbit_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && raddr1 != 5'd0) begin
            rdata1 = gpr_q[raddr1];
`ifdef WB_BYPASS_EN
            if (wb_wreg && wb_wd == raddr1) rdata1 = wb_wdata;
`endif
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && raddr2 != 5'd0) begin
            rdata2 = gpr_q[raddr2];
`ifdef WB_BYPASS_EN
            if (wb_wreg && wb_wd == raddr2) rdata2 = wb_wdata;
`endif
        end
    end

    always_comb begin
        hi_o    = '0;
        lo_o    = '0;
        LLbit_o = 1'b0;
        if (!rst) begin
`ifdef WB_BYPASS_EN
            hi_o    = wb_whilo ? wb_hi : hi_q;
            lo_o    = wb_whilo ? wb_lo : lo_q;
            LLbit_o = llbit_d;
`else
            hi_o    = hi_q;
            lo_o    = lo_q;
            LLbit_o = llbit_q;
`endif
        end
    end

endmodule

// File: tb/tb_wb_regbank.sv
// Randomized bench for wb_regbank against an array-based architectural model.
module tb_wb_regbank;
    localparam int DW = 32;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    wb_wd;
    logic          wb_wreg;
    logic [DW-1:0] wb_wdata, wb_hi, wb_lo;
    logic          wb_whilo, wb_LLbit_we, wb_LLbit_value, flush;
    logic          re1, re2;
    logic [4:0]    raddr1, raddr2;
    logic [DW-1:0] rdata1, rdata2, hi_o, lo_o;
    logic          LLbit_o;

    always #5 clk = ~clk;

    wb_regbank #(.NREGS(32), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value), .flush(flush),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o)
    );

    logic [DW-1:0] m_gpr [32];
    logic [DW-1:0] m_hi = '0, m_lo = '0;
    logic          m_ll = 1'b0;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic re, input logic [4:0] a);
        if (rst || !re || a == 5'd0) return '0;
        if (BYP && wb_wreg && wb_wd == a) return wb_wdata;
        return m_gpr[a];
    endfunction

    task automatic check_outs();
        logic          ll_e;
        chk("rdata1", rdata1, exp_rd(re1, raddr1));
        chk("rdata2", rdata2, exp_rd(re2, raddr2));
        chk("hi", hi_o, rst ? '0 : (BYP && wb_whilo) ? wb_hi : m_hi);
        chk("lo", lo_o, rst ? '0 : (BYP && wb_whilo) ? wb_lo : m_lo);
        if (rst)      ll_e = 1'b0;
        else if (!BYP) ll_e = m_ll;
        else          ll_e = flush ? 1'b0 : wb_LLbit_we ? wb_LLbit_value : m_ll;
        chk("llbit", {31'd0, LLbit_o}, {31'd0, ll_e});
    endtask

    // check outputs late in the cycle, then commit the model at the edge
    task automatic tick();
        #3;
        check_outs();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = '0;
            m_hi = '0; m_lo = '0; m_ll = 1'b0;
        end else begin
            if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
            if (wb_whilo) begin m_hi = wb_hi; m_lo = wb_lo; end
            if (flush) m_ll = 1'b0;
            else if (wb_LLbit_we) m_ll = wb_LLbit_value;
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; wb_wreg = 0; wb_wd = 0; wb_wdata = 0; wb_hi = 0; wb_lo = 0;
        wb_whilo = 0; wb_LLbit_we = 0; wb_LLbit_value = 0; flush = 0;
        re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        idle();
        // reset held with a write pending
        rst = 1; wb_wreg = 1; wb_wd = 5; wb_wdata = 32'hDEAD_BEEF;
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 5; wb_whilo = 1; wb_hi = 32'h55;
        #3 chk("rst_rdata1", rdata1, 32'h0);
        tick(); tick();
        idle(); re1 = 1; raddr1 = 5;
        #3 chk("post_rst_r5", rdata1, 32'h0);
        tick();

        // write then read
        wb_wreg = 1; wb_wd = 7; wb_wdata = 32'h1234_5678; tick();
        idle(); re1 = 1; raddr1 = 7;
        #3 chk("r7", rdata1, 32'h1234_5678);
        tick();
        re1 = 0; tick();

        // $0 protection
        wb_wreg = 1; wb_wd = 0; wb_wdata = 32'hFFFF_FFFF; tick();
        idle(); re1 = 1; re2 = 1; tick();

        // same-cycle read of the address being written
        wb_wreg = 1; wb_wd = 3; wb_wdata = 32'h1111_1111; tick();
        idle(); wb_wreg = 1; wb_wd = 3; wb_wdata = 32'hA5A5_A5A5; re2 = 1; raddr2 = 3;
        #3 chk("r3_same", rdata2, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
        tick();
        idle(); re2 = 1; raddr2 = 3;
        #3 chk("r3_next", rdata2, 32'hA5A5_A5A5);
        tick();

        // HI/LO
        idle(); wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2; tick();
        idle(); wb_hi = 32'h99; wb_lo = 32'h77;
        #3 chk("hi_hold", hi_o, 32'h1);
        tick();

        // LLbit priority
        idle(); wb_LLbit_we = 1; wb_LLbit_value = 1; tick();
        idle();
        #3 chk("ll_set", {31'd0, LLbit_o}, 32'd1);
        tick();
        flush = 1; wb_LLbit_we = 1; wb_LLbit_value = 1; tick();
        idle();
        #3 chk("ll_flush", {31'd0, LLbit_o}, 32'd0);
        tick();

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            rst            = ($urandom_range(0, 39) == 0);
            wb_wreg        = $urandom_range(0, 1);
            wb_wd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wb_wdata       = $urandom;
            wb_whilo       = ($urandom_range(0, 3) == 0);
            wb_hi          = $urandom;
            wb_lo          = $urandom;
            wb_LLbit_we    = $urandom_range(0, 1);
            wb_LLbit_value = $urandom_range(0, 1);
            flush          = ($urandom_range(0, 5) == 0);
            re1            = ($urandom_range(0, 3) != 0);
            re2            = ($urandom_range(0, 3) != 0);
            raddr1         = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom);
            raddr2         = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
